// File: rtl/ram_writer_64x8_if.sv
// Producer/reader bus of the 64x8 burst-write RAM: burst request, byte stream, status and read port.
interface ram_writer_64x8_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          busy;
    logic          done;
    logic          verify_err;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    modport master (
        output start, base_addr, length, s_valid, s_data, rd_addr,
        input  s_ready, busy, done, verify_err, rd_data
    );

    modport slave (
        input  start, base_addr, length, s_valid, s_data, rd_addr,
        output s_ready, busy, done, verify_err, rd_data
    );
endinterface

// File: rtl/ram_writer_64x8.sv
// 64x8 synchronous RAM with a streaming burst-write engine and a one-cycle registered read port.
// Defining RAM_WRITER_VERIFY_EN adds a checksum readback (VERIFY state) after every burst.
module ram_writer_64x8 #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    ram_writer_64x8_if.slave bus
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd3;
`ifdef RAM_WRITER_VERIFY_EN
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_AFTER_WRITE = S_VERIFY;
`else
    localparam logic [1:0] S_AFTER_WRITE = S_DONE;
`endif

    logic [1:0]    state;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   remaining;
    logic [AW:0]   clamped_len;
    logic [DW-1:0] rd_q;
    logic          start_ok;
    logic          accept;
    logic          last_byte;
    logic          verify_done;

    logic [DW-1:0]    mem [DEPTH];
    // Power-up image is mem[i] = i: each word reads back its own address until first written.
    logic [DEPTH-1:0] written = '0;

    function automatic logic [DW-1:0] read_word(input logic [AW-1:0] a);
        return written[a] ? mem[a] : DW'(a);
    endfunction

    assign clamped_len = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
    assign start_ok    = (state == S_IDLE) && bus.start;
    assign accept      = (state == S_WRITE) && bus.s_valid;
    assign last_byte   = accept && (remaining == (AW+1)'(1));

    assign bus.s_ready = (state == S_WRITE);
    assign bus.done    = (state == S_DONE);
    assign bus.rd_data = rd_q;

`ifdef RAM_WRITER_VERIFY_EN
    logic [AW-1:0] base_cap;
    logic [AW-1:0] ver_addr;
    logic [AW:0]   len_cap;
    logic [AW:0]   ver_cnt;
    logic [DW-1:0] wr_sum;
    logic [DW-1:0] ver_sum;
    logic [DW-1:0] ver_rd;
    logic [DW-1:0] ver_total;
    logic          verify_err_q;

    assign ver_total   = ver_sum + ver_rd;
    assign verify_done = (state == S_VERIFY) && (ver_cnt == len_cap);
    assign bus.busy    = (state == S_WRITE) || (state == S_VERIFY);
    assign bus.verify_err = verify_err_q;

    // Reads are issued for len_cap cycles; the extra final cycle only absorbs the last read's latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_cap     <= '0;
            ver_addr     <= '0;
            len_cap      <= '0;
            ver_cnt      <= '0;
            wr_sum       <= '0;
            ver_sum      <= '0;
            ver_rd       <= '0;
            verify_err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                wr_sum       <= '0;
                verify_err_q <= 1'b0;
                base_cap     <= bus.base_addr;
                len_cap      <= clamped_len;
            end
            if (accept) begin
                wr_sum <= wr_sum + bus.s_data;
            end
            if (last_byte) begin
                ver_addr <= base_cap;
                ver_cnt  <= '0;
                ver_sum  <= '0;
            end
            if (state == S_VERIFY) begin
                if (ver_cnt != len_cap) begin
                    ver_rd   <= read_word(ver_addr);
                    ver_addr <= ver_addr + AW'(1);
                    ver_cnt  <= ver_cnt + (AW+1)'(1);
                end
                if (ver_cnt != '0) begin
                    ver_sum <= ver_total;
                end
                if (verify_done && (ver_total != wr_sum)) begin
                    verify_err_q <= 1'b1;
                end
            end
        end
    end
`else
    assign verify_done    = 1'b0;
    assign bus.busy       = (state == S_WRITE);
    assign bus.verify_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_addr   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        if (clamped_len == '0) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_WRITE;
                            wr_addr   <= bus.base_addr;
                            remaining <= clamped_len;
                        end
                    end
                end
                S_WRITE: begin
                    if (accept) begin
                        wr_addr   <= wr_addr + AW'(1);
                        remaining <= remaining - (AW+1)'(1);
                        if (last_byte) begin
                            state <= S_AFTER_WRITE;
                        end
                    end
                end
`ifdef RAM_WRITER_VERIFY_EN
                S_VERIFY: begin
                    if (verify_done) begin
                        state <= S_DONE;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory contents deliberately survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr]     <= bus.s_data;
            written[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= read_word(bus.rd_addr);
        end
    end
endmodule

// File: tb/tb_ram_writer_64x8.sv
// Scoreboard bench for ram_writer_64x8: directed plan scenarios plus randomized bursts and reads
// checked against an array model of the RAM and a cycle-level model of the burst protocol.
`timescale 1ns/1ps
module tb_ram_writer_64x8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_writer_64x8_if #(.AW(6), .DW(8)) bus ();
    ram_writer_64x8 #(.AW(6), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef RAM_WRITER_VERIFY_EN
    localparam int VERIFY_ON = 1;
`else
    localparam int VERIFY_ON = 0;
`endif

    typedef struct { int cyc; logic err; } done_t;

    done_t      done_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] model_mem [64];
    int         cyc = 0;
    logic       rd_en = 1'b0;
    logic       rd_pend;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         model_writing = 1'b0;
    int         busy_end = 0;
    int         idle_from = 0;
    logic [5:0] model_waddr = '0;
    int         model_rem = 0;
    int         model_len = 0;
    logic       expect_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) rd_pend <= 1'b0;
        else     rd_pend <= rd_en;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops expected read data and done events whenever the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                checkOutput("done_expected", (done_q.size() > 0) ? 1 : 0, 1);
                if (done_q.size() > 0) begin
                    done_t e;
                    e = done_q.pop_front();
                    checkOutput("done_cycle", cyc, e.cyc);
                    checkOutput("done_verify_err", bus.verify_err, e.err);
                end
            end
            if (rd_pend) begin
                checkOutput("rd_expected", (rd_q.size() > 0) ? 1 : 0, 1);
                if (rd_q.size() > 0) checkOutput("rd_data", bus.rd_data, rd_q.pop_front());
            end
        end
    end

    // One clock of stimulus; updates the protocol model and queues expected responses.
    task automatic applyStimulus(input bit st, input logic [5:0] ba, input int ln, input bit v,
                                 input logic [7:0] d, input bit re, input logic [5:0] ra);
        int    len;
        int    m;
        done_t e;
        bus.start     = st;
        bus.base_addr = ba;
        bus.length    = 7'(ln);
        bus.s_valid   = v;
        bus.s_data    = d;
        rd_en         = re;
        bus.rd_addr   = ra;
        #1;
        checkOutput("s_ready", bus.s_ready, model_writing);
        checkOutput("busy", bus.busy, (model_writing || (cyc < busy_end)) ? 1 : 0);
        if (VERIFY_ON == 0) checkOutput("verify_err_tied", bus.verify_err, 0);
        if (re) rd_q.push_back(model_mem[ra]);
        if (st && !model_writing && cyc >= idle_from) begin
            len = (ln > 64) ? 64 : ln;
            if (len == 0) begin
                e.cyc = cyc + 1;
                e.err = 1'b0;
                done_q.push_back(e);
                idle_from = cyc + 2;
            end else begin
                model_writing = 1'b1;
                model_waddr   = ba;
                model_rem     = len;
                model_len     = len;
            end
        end else if (model_writing && v) begin
            model_mem[model_waddr] = d;
            model_waddr = model_waddr + 6'd1;
            model_rem--;
            if (model_rem == 0) begin
                model_writing = 1'b0;
                m = cyc + 1;
                e.cyc = m + ((VERIFY_ON != 0) ? model_len + 1 : 0);
                e.err = expect_err;
                done_q.push_back(e);
                busy_end  = e.cyc;
                idle_from = e.cyc + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 6'd0, 0, 1'b0, 8'd0, 1'b0, 6'd0);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((model_writing || done_q.size() != 0 || cyc < idle_from) && guard < 300) begin
            idleStep();
            guard++;
        end
        checkOutput("idle_reached", (guard < 300) ? 1 : 0, 1);
        idleStep();
    endtask

    task automatic readRange(input int first, input int count);
        for (int i = 0; i < count; i++) applyStimulus(1'b0, 6'd0, 0, 1'b0, 8'd0, 1'b1, 6'(first + i));
        idleStep();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = 8'(i);
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.rd_addr = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_s_ready", bus.s_ready, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_verify_err", bus.verify_err, 0);
        checkOutput("rst_rd_data", bus.rd_data, 0);
        rst = 1'b0;

        // Untouched memory reads back its own address.
        readRange(0, 64);

        // Back-to-back burst at 0x10.
        applyStimulus(1'b1, 6'h10, 4, 1'b0, 8'h00, 1'b0, 6'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'(8'hA0 + i), 1'b0, 6'd0);
        waitIdle();
        readRange(16, 5);

        // Wrapping burst at 62 with a 3-cycle gap between bytes 2 and 3.
        applyStimulus(1'b1, 6'd62, 4, 1'b0, 8'h00, 1'b0, 6'd0);
        applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'h11, 1'b0, 6'd0);
        applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'h22, 1'b0, 6'd0);
        repeat (3) applyStimulus(1'b0, 6'd0, 0, 1'b0, 8'hEE, 1'b0, 6'd0);
        applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'h33, 1'b0, 6'd0);
        applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'h44, 1'b0, 6'd0);
        waitIdle();
        readRange(62, 4);

        // Zero length, then an over-long length clamped to 64.
        applyStimulus(1'b1, 6'd5, 0, 1'b0, 8'h00, 1'b0, 6'd0);
        waitIdle();
        applyStimulus(1'b1, 6'd7, 100, 1'b0, 8'h00, 1'b0, 6'd0);
        for (int i = 0; i < 66; i++) applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'(8'hC0 ^ i), 1'b0, 6'd0);
        waitIdle();
        readRange(0, 64);

        // Reset after 2 of 5 bytes; the second cycle also carries an ignored start.
        applyStimulus(1'b1, 6'd40, 5, 1'b0, 8'h00, 1'b0, 6'd0);
        applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'h5C, 1'b0, 6'd0);
        applyStimulus(1'b1, 6'd3, 3, 1'b1, 8'h6D, 1'b0, 6'd0);
        bus.start = 1'b0; bus.s_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_s_ready", bus.s_ready, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_done", bus.done, 0);
        model_writing = 1'b0; busy_end = 0; idle_from = 0;
        @(negedge clk);
        rst = 1'b0;
        readRange(38, 8);

        // Randomized bursts with random gaps, stray starts and interleaved reads.
        for (int b = 0; b < 25; b++) begin
            int guard;
            applyStimulus(1'b1, 6'($urandom), $urandom_range(0, 70), 1'b0, 8'h00, 1'b0, 6'd0);
            guard = 0;
            while (model_writing && guard < 2000) begin
                applyStimulus(($urandom_range(0, 7) == 0), 6'($urandom), $urandom_range(0, 70),
                              ($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 1) != 0,
                              ($urandom_range(0, 1) != 0) ? model_waddr : 6'($urandom));
                guard++;
            end
            waitIdle();
        end

`ifdef RAM_WRITER_VERIFY_EN
        // Clean verify with reads held on the address being written.
        applyStimulus(1'b1, 6'h30, 3, 1'b0, 8'h00, 1'b0, 6'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'(8'h71 + i), 1'b1, model_waddr);
        waitIdle();
        // Corrupt a word during VERIFY so the checksum cannot match.
        expect_err = 1'b1;
        applyStimulus(1'b1, 6'd32, 3, 1'b0, 8'h00, 1'b0, 6'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'(i + 1), 1'b0, 6'd0);
        force dut.mem[32] = 8'h5A;
        expect_err = 1'b0;
        waitIdle();
        release dut.mem[32];
        model_mem[32] = 8'h5A;
        repeat (2) idleStep();
        checkOutput("verify_err_sticky", bus.verify_err, 1);
        applyStimulus(1'b1, 6'd50, 1, 1'b0, 8'h00, 1'b0, 6'd0);
        checkOutput("verify_err_cleared", bus.verify_err, 0);
        applyStimulus(1'b0, 6'd0, 0, 1'b1, 8'h99, 1'b0, 6'd0);
        waitIdle();
`endif

        readRange(0, 64);
        idleStep();
        checkOutput("rd_q_drained", rd_q.size(), 0);
        checkOutput("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_writer_64x8.md
# ram_writer_64x8

Writable counterpart to the team's 64x8 synchronous ROM: a 64x8 synchronous RAM with a streaming burst-write engine in front of it. A producer hands over a base address and length, then streams bytes over a valid/ready handshake. The engine writes them at auto-incrementing, wrapping addresses. An independent read port has the same one-cycle registered latency as the ROM, so downstream readers can swap one for the other.

## Interface
- `AW`, 6, address width; depth = 2^AW = 64
- `DW`, 8, data width
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: burst request, sampled only in IDLE
- `base_addr` in AW: first write address, captured on accepted `start`
- `length` in AW+1: byte count 0..64, captured on accepted `start`; values >64 clamp to 64
- `s_valid` in 1: write byte valid
- `s_data` in DW: write byte
- `s_ready` out 1: engine accepts a byte this cycle
- `busy` out 1: engine is in WRITE or VERIFY
- `done` out 1: one-cycle pulse when a burst completes
- `verify_err` out 1: readback mismatch, sticky (see Configuration)
- `rd_addr` in AW: read address
- `rd_data` out DW: registered read data

## Operation
- Memory is initialised at time zero with `mem[i] = i`. Reset never clears memory contents.
- States: IDLE, WRITE, VERIFY (macro only), DONE.
- **IDLE**
  - With `start=1` and clamped length ≥1: capture `wr_addr=base_addr`, `remaining=length`, and go to WRITE.
  - With `start=1` and length 0: go straight to DONE.
  - A new accepted `start` also clears `verify_err` and the checksum.
  - `start` is ignored in all other states.
- **WRITE**
  - `s_ready=1`. Each cycle with `s_valid && s_ready`:
    - write `mem[wr_addr] <= s_data`;
    - `wr_addr <= wr_addr+1` mod 64 (63 wraps to 0);
    - `remaining` decrements.
  - Gaps with `s_valid=0` stall without limit.
  - When the last byte is accepted: go to VERIFY if compiled in, else DONE.
- **DONE**: `done=1` for exactly one cycle, then IDLE.
- **Read port**
  - `rd_data <= mem[rd_addr]` every cycle, independent of engine state.
  - A same-cycle write to the same address returns the old data (read-before-write).

## Timing
- Values after reset: state IDLE, `s_ready=0`, `busy=0`, `done=0`, `verify_err=0`, `rd_data=0`.
- `start` is accepted at edge N. WRITE, `s_ready=1` and `busy=1` are all visible after edge N.
- Final byte is accepted at edge M. Without the macro, `done=1` and `busy=0` during cycle M+1, and `s_ready=0` immediately after edge M.
- With the macro, VERIFY occupies `length+1` cycles after edge M, then DONE.
- A length-0 start gives `done` the cycle after acceptance, with no write.
- Read latency is exactly one clock. A written byte is visible on `rd_data` one cycle after the next edge that samples its address following the write edge.
- An asynchronous `rst` mid-burst returns the engine to IDLE immediately and drops `s_ready`, `busy` and `done`. Bytes already written remain in memory.

## Configuration
- `RAM_WRITER_VERIFY_EN` defined:
  - During WRITE, accumulate an 8-bit mod-256 sum of accepted bytes.
  - VERIFY uses an internal second read port to read the `length` locations from `base_addr` (wrapping), one per cycle, and sums them. One extra cycle drains the read latency.
  - On mismatch, set `verify_err` (sticky until the next accepted `start`). Then go to DONE.
  - `busy=1` throughout VERIFY. `s_ready=0`.
- Undefined: no VERIFY state or checksum logic. WRITE goes directly to DONE. `verify_err` is tied 0.

## Test plan
- Reset, then read addresses 0..63 with no writes -> `rd_data` equals the address one cycle later; all outputs hold their reset values.
- Start with base 0x10, length 4, stream 0xA0..0xA3 back-to-back -> `done` pulses once, 1 cycle after the last accept (macro off); reads of 0x10..0x13 return 0xA0..0xA3; 0x14 still reads 0x14.
- Start with base 62, length 4, bytes 0x11,0x22,0x33,0x44, with `s_valid` low for 3 cycles between bytes 2 and 3 -> addresses 62,63,0,1 hold the bytes in order; `s_ready` stays high through the gap.
- Length 0 start -> `done` the next cycle, no memory change. Length 100 -> exactly 64 bytes accepted; `s_ready` low after the 64th.
- Reset asserted after 2 of 5 bytes, then released -> IDLE with `busy=0`; the first 2 bytes are in memory and the other 3 locations are unchanged. A `start` pulse during WRITE is ignored.
- Macro on, length 3, with `rd_addr` held at the burst address during writes -> `done` at M+5 and `verify_err=0`. Force a mismatch by `force` on a memory word during VERIFY -> `verify_err=1`, held until the next `start`.
